// File: rtl/noc_router_pkg.sv
// Shared types and constants for the noc_router mesh router (flit codes, port ids, header fields).
package noc_router_pkg;

  localparam int FLIT_W  = 32;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 3;
  localparam int COORD_W = 2;
  localparam int NPORTS  = 5;

  localparam logic [1:0] FT_IDLE = 2'b00;
  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_BODY = 2'b10;
  localparam logic [1:0] FT_TAIL = 2'b11;

  localparam int TYPE_HI = 31;
  localparam int TYPE_LO = 30;
  localparam int DSTX_HI = 23;
  localparam int DSTX_LO = 22;
  localparam int DSTY_HI = 21;
  localparam int DSTY_LO = 20;

  typedef enum logic [2:0] {
    P_LOCAL = 3'd0,
    P_NORTH = 3'd1,
    P_SOUTH = 3'd2,
    P_WEST  = 3'd3,
    P_EAST  = 3'd4
  } port_e;

  // Dimension-ordered XY routing: resolve X first, then Y (north is +Y).
  function automatic port_e route_xy(input logic [COORD_W-1:0] dst_x, input logic [COORD_W-1:0] dst_y,
                                     input logic [COORD_W-1:0] cur_x, input logic [COORD_W-1:0] cur_y);
    if (dst_x > cur_x) return P_EAST;
    if (dst_x < cur_x) return P_WEST;
    if (dst_y > cur_y) return P_NORTH;
    if (dst_y < cur_y) return P_SOUTH;
    return P_LOCAL;
  endfunction

  // Round-robin visiting order: local, north, east, south, west.
  function automatic port_e rr_port(input logic [2:0] pos);
    case (pos)
      3'd1:    return P_NORTH;
      3'd2:    return P_EAST;
      3'd3:    return P_SOUTH;
      3'd4:    return P_WEST;
      default: return P_LOCAL;
    endcase
  endfunction

endpackage

// File: rtl/noc_router_in_fifo.sv
// router_in_fifo: 4-entry circular input FIFO; idle flits and writes while full are discarded.
module router_in_fifo
  import noc_router_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              push,
  input  logic              pop,
  input  logic [FLIT_W-1:0] din,
  output logic [FLIT_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [1:0]        rd_ptr, wr_ptr;
  logic              do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = enable && push && (din[TYPE_HI:TYPE_LO] != FT_IDLE) && !full;
  assign do_pop  = enable && pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/noc_router.sv
// noc_router: 5-port wormhole XY mesh router with per-output locks and round-robin header arbitration.
// Build option: define ROUTER_CREDIT_EN to stall an output while the downstream FIFO is full.
module noc_router
  import noc_router_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [COORD_W-1:0] routeridx,
  input  logic [COORD_W-1:0] routeridy,
  input  logic [FLIT_W-1:0]  local_in, north_in, south_in, west_in, east_in,
  input  logic               push_local, push_north, push_south, push_west, push_east,
  output logic [FLIT_W-1:0]  local_out, north_out, south_out, west_out, east_out,
  output logic               pop_local, pop_north, pop_south, pop_west, pop_east,
  output logic [CNT_W-1:0]   count_out_l, count_out_n, count_out_s, count_out_w, count_out_e,
  input  logic [CNT_W-1:0]   count_in_l, count_in_n, count_in_s, count_in_w, count_in_e
);

  logic [FLIT_W-1:0] in_flit [NPORTS];
  logic [FLIT_W-1:0] head    [NPORTS];
  logic [FLIT_W-1:0] out_q   [NPORTS];
  logic [CNT_W-1:0]  cnt     [NPORTS];
  logic [CNT_W-1:0]  cnt_in  [NPORTS];
  logic [NPORTS-1:0] push_v, pop_req, pop_q, fifo_empty, fifo_full_unused;
  logic [NPORTS-1:0] want, drop_orphan, release_hh, can_send;
  port_e             want_port [NPORTS];
  logic [NPORTS-1:0] in_lock_vld, out_lock_vld;
  port_e             in_lock_out [NPORTS];
  port_e             out_owner   [NPORTS];
  logic [2:0]        rr_ptr      [NPORTS];
  logic [NPORTS-1:0] grant_vld;
  port_e             grant_in    [NPORTS];
  logic [2:0]        grant_pos   [NPORTS];

  assign in_flit[P_LOCAL] = local_in;   assign push_v[P_LOCAL] = push_local;  assign cnt_in[P_LOCAL] = count_in_l;
  assign in_flit[P_NORTH] = north_in;   assign push_v[P_NORTH] = push_north;  assign cnt_in[P_NORTH] = count_in_n;
  assign in_flit[P_SOUTH] = south_in;   assign push_v[P_SOUTH] = push_south;  assign cnt_in[P_SOUTH] = count_in_s;
  assign in_flit[P_WEST]  = west_in;    assign push_v[P_WEST]  = push_west;   assign cnt_in[P_WEST]  = count_in_w;
  assign in_flit[P_EAST]  = east_in;    assign push_v[P_EAST]  = push_east;   assign cnt_in[P_EAST]  = count_in_e;

  for (genvar g = 0; g < NPORTS; g++) begin : g_fifo
    router_in_fifo u_fifo (
      .clk(clk), .reset(reset), .enable(enable),
      .push(push_v[g]), .pop(pop_req[g]), .din(in_flit[g]),
      .dout(head[g]), .count(cnt[g]), .full(fifo_full_unused[g]), .empty(fifo_empty[g])
    );
`ifdef ROUTER_CREDIT_EN
    assign can_send[g] = (cnt_in[g] < CNT_W'(DEPTH));
`else
    logic unused_credit;
    assign unused_credit = ^cnt_in[g];
    assign can_send[g]   = 1'b1;
`endif
  end

  // Per input: a locked input follows its path; a header arriving on a locked input ends the old packet first.
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      want[i]        = 1'b0;
      want_port[i]   = P_LOCAL;
      drop_orphan[i] = 1'b0;
      release_hh[i]  = 1'b0;
      if (!fifo_empty[i]) begin
        if (in_lock_vld[i]) begin
          if (head[i][TYPE_HI:TYPE_LO] == FT_HEAD) begin
            release_hh[i] = 1'b1;
          end else begin
            want[i]      = 1'b1;
            want_port[i] = in_lock_out[i];
          end
        end else if (head[i][TYPE_HI:TYPE_LO] == FT_HEAD) begin
          want[i]      = 1'b1;
          want_port[i] = route_xy(head[i][DSTX_HI:DSTX_LO], head[i][DSTY_HI:DSTY_LO], routeridx, routeridy);
        end else begin
          drop_orphan[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    int    p;
    port_e cand;
    p    = 0;
    cand = P_LOCAL;
    for (int o = 0; o < NPORTS; o++) begin
      grant_vld[o] = 1'b0;
      grant_in[o]  = P_LOCAL;
      grant_pos[o] = '0;
      if (can_send[o]) begin
        if (out_lock_vld[o]) begin
          if (want[out_owner[o]] && (want_port[out_owner[o]] == 3'(o))) begin
            grant_vld[o] = 1'b1;
            grant_in[o]  = out_owner[o];
          end
        end else begin
          for (int k = 0; k < NPORTS; k++) begin
            p = int'(rr_ptr[o]) + k;
            if (p >= NPORTS) p = p - NPORTS;
            cand = rr_port(3'(p));
            if (!grant_vld[o] && want[cand] && !in_lock_vld[cand] && (want_port[cand] == 3'(o))) begin
              grant_vld[o] = 1'b1;
              grant_in[o]  = cand;
              grant_pos[o] = 3'(p);
            end
          end
        end
      end
    end
  end

  always_comb begin
    pop_req = drop_orphan;
    for (int o = 0; o < NPORTS; o++) begin
      if (grant_vld[o]) pop_req[grant_in[o]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NPORTS; p++) begin
        out_q[p]       <= '0;
        rr_ptr[p]      <= '0;
        out_owner[p]   <= P_LOCAL;
        in_lock_out[p] <= P_LOCAL;
      end
      pop_q        <= '0;
      in_lock_vld  <= '0;
      out_lock_vld <= '0;
    end else if (!enable) begin
      for (int p = 0; p < NPORTS; p++) out_q[p] <= '0;
      pop_q <= '0;
    end else begin
      pop_q <= pop_req;
      for (int o = 0; o < NPORTS; o++) begin
        out_q[o] <= grant_vld[o] ? head[grant_in[o]] : '0;
        if (grant_vld[o]) begin
          if (!out_lock_vld[o]) begin
            out_lock_vld[o]          <= 1'b1;
            out_owner[o]             <= grant_in[o];
            in_lock_vld[grant_in[o]] <= 1'b1;
            in_lock_out[grant_in[o]] <= port_e'(3'(o));
            rr_ptr[o] <= (grant_pos[o] == 3'(NPORTS - 1)) ? 3'd0 : grant_pos[o] + 3'd1;
          end
          if (head[grant_in[o]][TYPE_HI:TYPE_LO] == FT_TAIL) begin
            out_lock_vld[o]          <= 1'b0;
            in_lock_vld[grant_in[o]] <= 1'b0;
          end
        end
      end
      for (int i = 0; i < NPORTS; i++) begin
        if (release_hh[i]) begin
          in_lock_vld[i]                <= 1'b0;
          out_lock_vld[in_lock_out[i]]  <= 1'b0;
        end
      end
    end
  end

  assign local_out   = enable ? out_q[P_LOCAL] : '0;
  assign north_out   = enable ? out_q[P_NORTH] : '0;
  assign south_out   = enable ? out_q[P_SOUTH] : '0;
  assign west_out    = enable ? out_q[P_WEST]  : '0;
  assign east_out    = enable ? out_q[P_EAST]  : '0;
  assign pop_local   = enable & pop_q[P_LOCAL];
  assign pop_north   = enable & pop_q[P_NORTH];
  assign pop_south   = enable & pop_q[P_SOUTH];
  assign pop_west    = enable & pop_q[P_WEST];
  assign pop_east    = enable & pop_q[P_EAST];
  assign count_out_l = enable ? cnt[P_LOCAL] : '0;
  assign count_out_n = enable ? cnt[P_NORTH] : '0;
  assign count_out_s = enable ? cnt[P_SOUTH] : '0;
  assign count_out_w = enable ? cnt[P_WEST]  : '0;
  assign count_out_e = enable ? cnt[P_EAST]  : '0;

endmodule

// File: tb/tb_noc_router.sv
// Directed bench for noc_router: routing, wormhole locking, arbitration, saturation, reset and enable.
module tb_noc_router;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic [1:0]  routeridx = 2'd0, routeridy = 2'd0;
  logic [31:0] local_in = '0, north_in = '0, south_in = '0, west_in = '0, east_in = '0;
  logic        push_local = 1'b0, push_north = 1'b0, push_south = 1'b0, push_west = 1'b0, push_east = 1'b0;
  logic [2:0]  count_in_l = '0, count_in_n = '0, count_in_s = '0, count_in_w = '0, count_in_e = '0;
  logic [31:0] local_out, north_out, south_out, west_out, east_out;
  logic        pop_local, pop_north, pop_south, pop_west, pop_east;
  logic [2:0]  count_out_l, count_out_n, count_out_s, count_out_w, count_out_e;

  int n_cmp = 0;
  int n_err = 0;

  noc_router dut (
    .clk(clk), .reset(reset), .enable(enable), .routeridx(routeridx), .routeridy(routeridy),
    .local_in(local_in), .north_in(north_in), .south_in(south_in), .west_in(west_in), .east_in(east_in),
    .push_local(push_local), .push_north(push_north), .push_south(push_south),
    .push_west(push_west), .push_east(push_east),
    .local_out(local_out), .north_out(north_out), .south_out(south_out), .west_out(west_out), .east_out(east_out),
    .pop_local(pop_local), .pop_north(pop_north), .pop_south(pop_south), .pop_west(pop_west), .pop_east(pop_east),
    .count_out_l(count_out_l), .count_out_n(count_out_n), .count_out_s(count_out_s),
    .count_out_w(count_out_w), .count_out_e(count_out_e),
    .count_in_l(count_in_l), .count_in_n(count_in_n), .count_in_s(count_in_s),
    .count_in_w(count_in_w), .count_in_e(count_in_e)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    local_in = '0; north_in = '0; south_in = '0; west_in = '0; east_in = '0;
    push_local = 1'b0; push_north = 1'b0; push_south = 1'b0; push_west = 1'b0; push_east = 1'b0;
  endtask

  task automatic do_reset(input logic [1:0] x, input logic [1:0] y);
    idle_inputs();
    reset = 1'b0;
    routeridx = x;
    routeridy = y;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic check_all_quiet(input string tag);
    check({tag, "_outs"}, local_out | north_out | south_out | west_out | east_out, 32'd0);
    check({tag, "_pops"}, 32'({pop_local, pop_north, pop_south, pop_west, pop_east}), 32'd0);
    check({tag, "_cnts"}, 32'({count_out_l, count_out_n, count_out_s, count_out_w, count_out_e}), 32'd0);
  endtask

  initial begin
    // Reset state
    do_reset(2'd0, 2'd0);
    check_all_quiet("reset_state");

    // Router (0,0): header/body/tail from local travel east on consecutive cycles
    local_in = 32'h435A_BCDE; push_local = 1'b1;
    step();
    check("t2_cnt_after_h", 32'(count_out_l), 32'd1);
    check("t2_east_idle", east_out, 32'd0);
    local_in = 32'h8000_1111;
    step();
    check("t2_east_h", east_out, 32'h435A_BCDE);
    check("t2_pop_h", 32'(pop_local), 32'd1);
    check("t2_cnt_mid", 32'(count_out_l), 32'd1);
    local_in = 32'hC000_2222;
    step();
    check("t2_east_b", east_out, 32'h8000_1111);
    push_local = 1'b0;
    step();
    check("t2_east_t", east_out, 32'hC000_2222);
    check("t2_cnt_end", 32'(count_out_l), 32'd0);
    step();
    check("t2_east_hold1", east_out, 32'd0);
    check("t2_local_out", local_out, 32'd0);

    // Asynchronous reset in the middle of a packet
    do_reset(2'd0, 2'd0);
    local_in = 32'h435A_BCDE; push_local = 1'b1;
    step();
    local_in = 32'h8000_1111;
    step();
    check("t1_pre_east", east_out, 32'h435A_BCDE);
    #2;
    reset = 1'b0;
    #1;
    check_all_quiet("t1_async");
    push_local = 1'b0;
    #2;
    reset = 1'b1;
    step();
    check_all_quiet("t1_after1");
    step();
    check_all_quiet("t1_after2");

    // XY routing directions
    do_reset(2'd1, 2'd0);
    local_in = 32'h4010_0123; push_local = 1'b1;
    step();
    push_local = 1'b0;
    step();
    check("t3_west", west_out, 32'h4010_0123);
    check("t3_not_east", east_out, 32'd0);

    do_reset(2'd0, 2'd0);
    west_in = 32'h4000_00AB; push_west = 1'b1;
    step();
    push_west = 1'b0;
    step();
    check("t3_local", local_out, 32'h4000_00AB);
    check("t3_pop_west", 32'(pop_west), 32'd1);

    do_reset(2'd1, 2'd0);
    local_in = 32'h4060_0001; push_local = 1'b1;
    step();
    push_local = 1'b0;
    step();
    check("t3_north", north_out, 32'h4060_0001);

    do_reset(2'd1, 2'd1);
    local_in = 32'h4040_0002; push_local = 1'b1;
    step();
    push_local = 1'b0;
    step();
    check("t3_south", south_out, 32'h4040_0002);

    // Two packets contending for local: north wins round robin, west follows without interleaving
    do_reset(2'd1, 2'd1);
    north_in = 32'h4050_0001; west_in = 32'h4050_0002; push_north = 1'b1; push_west = 1'b1;
    step();
    check("t4_c1_local", local_out, 32'd0);
    north_in = 32'h8000_0011; west_in = 32'h8000_0012;
    step();
    check("t4_c2_local", local_out, 32'h4050_0001);
    check("t4_c2_popw", 32'(pop_west), 32'd0);
    check("t4_c2_cntw", 32'(count_out_w), 32'd2);
    north_in = 32'hC000_0021; west_in = 32'hC000_0022;
    step();
    check("t4_c3_local", local_out, 32'h8000_0011);
    idle_inputs();
    step();
    check("t4_c4_local", local_out, 32'hC000_0021);
    check("t4_c4_cntw", 32'(count_out_w), 32'd3);
    step();
    check("t4_c5_local", local_out, 32'h4050_0002);
    step();
    check("t4_c6_local", local_out, 32'h8000_0012);
    step();
    check("t4_c7_local", local_out, 32'hC000_0022);
    step();
    check("t4_c8_local", local_out, 32'd0);

    // Saturation: west holds east, local queues five headers, fifth is dropped
    do_reset(2'd0, 2'd0);
    west_in = 32'h4050_0000; push_west = 1'b1;
    step();
    push_west = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      local_in = 32'h4050_0000 | 32'(k); push_local = 1'b1;
      step();
      if (k == 1) check("t5_east_wh", east_out, 32'h4050_0000);
    end
    push_local = 1'b0;
    step();
    check("t5_cnt_sat", 32'(count_out_l), 32'd4);
    check("t5_east_blocked", east_out, 32'd0);
    check("t5_pop_blocked", 32'(pop_local), 32'd0);
    west_in = 32'hC000_0000; push_west = 1'b1;
    step();
    push_west = 1'b0;
    step();
    check("t5_east_wt", east_out, 32'hC000_0000);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("t5_drain_h", east_out, 32'h4050_0000 | 32'(k));
      step();
      check("t5_drain_gap", east_out, 32'd0);
    end
    step();
    check("t5_fifth_dropped", east_out, 32'd0);
    check("t5_cnt_empty", 32'(count_out_l), 32'd0);

`ifdef ROUTER_CREDIT_EN
    // Credit stall: east holds until downstream occupancy drops below four
    do_reset(2'd0, 2'd0);
    count_in_e = 3'd4;
    local_in = 32'h4050_0077; push_local = 1'b1;
    step();
    push_local = 1'b0;
    step();
    check("t5c_stall1", east_out, 32'd0);
    step();
    check("t5c_stall2", east_out, 32'd0);
    check("t5c_cnt_held", 32'(count_out_l), 32'd1);
    count_in_e = 3'd3;
    step();
    check("t5c_release", east_out, 32'h4050_0077);
    count_in_e = 3'd0;
`endif

    // Idle flits with push asserted are never stored
    do_reset(2'd0, 2'd0);
    push_local = 1'b1; push_north = 1'b1; push_south = 1'b1; push_west = 1'b1; push_east = 1'b1;
    step();
    step();
    step();
    check_all_quiet("t6_idle");
    idle_inputs();
    step();
    check_all_quiet("t6_after");

    // Enable low: pushes ignored, outputs forced to zero, state kept
    do_reset(2'd0, 2'd0);
    enable = 1'b0;
    local_in = 32'h4050_0055; push_local = 1'b1;
    step();
    enable = 1'b1;
    push_local = 1'b0;
    step();
    check("en_push_ignored_cnt", 32'(count_out_l), 32'd0);
    check("en_push_ignored_out", east_out, 32'd0);
    local_in = 32'h4050_0066; push_local = 1'b1;
    step();
    push_local = 1'b0;
    enable = 1'b0;
    step();
    check("en_off_out", east_out, 32'd0);
    check("en_off_cnt", 32'(count_out_l), 32'd0);
    enable = 1'b1;
    #1;
    check("en_on_cnt_kept", 32'(count_out_l), 32'd1);
    step();
    check("en_on_forward", east_out, 32'h4050_0066);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
